// File: rtl/klp32_alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, ALU select codes, issue entry layout.
package klp32_alu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU select encodings; bit 3 selects the alternate form (SUB/SRA)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0]      x;
        logic [XLEN-1:0]      y;
        logic [3:0]           select;
        logic [XLEN-1:0]      rs2_val;
        logic [REG_IDX_W-1:0] rd;
        logic                 illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of instruction fields into an ALU issue entry.
module alu_op_decode
    import klp32_alu_pkg::*;
(
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rs1_val,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [XLEN-1:0]      imm,
    input  logic [REG_IDX_W-1:0] rd,
    output issue_entry_t         entry
);

    // Operand/select selection by opcode; illegal encodings are squashed to zero operands
    always_comb begin
        entry         = '0;
        entry.rs2_val = rs2_val;
        entry.rd      = rd;
        unique case (opcode)
            OPC_OP: begin
                entry.x      = rs1_val;
                entry.y      = rs2_val;
                entry.select = {funct7[5], funct3};
                if (!((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    entry.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                entry.x      = rs1_val;
                entry.y      = imm;
                // Only the shift-right immediate uses funct7[5] (SRAI vs SRLI)
                entry.select = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
            end
            OPC_LUI: begin
                entry.y      = imm;
                entry.select = ALU_PASS;
            end
            OPC_AUIPC, OPC_JAL: begin
                entry.x = pc;
                entry.y = imm;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                entry.x = rs1_val;
                entry.y = imm;
            end
            OPC_BRANCH: begin
                entry.x = rs1_val;
                entry.y = rs2_val;
                unique case (funct3)
                    3'b000, 3'b001: entry.select = ALU_SUB;
                    3'b100, 3'b101: entry.select = ALU_SLT;
                    3'b110, 3'b111: entry.select = ALU_SLTU;
                    default:        entry.illegal = 1'b1;
                endcase
            end
            default: entry.illegal = 1'b1;
        endcase
        if (entry.illegal) begin
            entry.x      = '0;
            entry.y      = '0;
            entry.select = ALU_ADD;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decode, optional writeback forwarding, 2-entry skid buffer toward the ALU.
// Optional feature macro: ALU_ISSUE_FWD_EN adds writeback forwarding ports and muxes.
module alu_issue_stage
    import klp32_alu_pkg::*;
#(
    parameter int unsigned n    = 32,
    parameter int unsigned RIDX = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [n-1:0]    in_pc,
    input  logic [n-1:0]    in_rs1_val,
    input  logic [n-1:0]    in_rs2_val,
    input  logic [n-1:0]    in_imm,
    input  logic [RIDX-1:0] in_rd,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [RIDX-1:0] in_rs1_idx,
    input  logic [RIDX-1:0] in_rs2_idx,
    input  logic            wb_valid,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [n-1:0]    wb_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    out_x,
    output logic [n-1:0]    out_y,
    output logic [3:0]      out_select,
    output logic [n-1:0]    out_rs2_val,
    output logic [RIDX-1:0] out_rd,
    output logic            out_illegal
);

    logic [n-1:0] rs1_eff;
    logic [n-1:0] rs2_eff;

`ifdef ALU_ISSUE_FWD_EN
    // Bypass a same-cycle writeback onto the source values; x0 never forwards
    always_comb begin
        rs1_eff = in_rs1_val;
        rs2_eff = in_rs2_val;
        if (wb_valid && (wb_rd == in_rs1_idx) && (in_rs1_idx != '0)) rs1_eff = wb_data;
        if (wb_valid && (wb_rd == in_rs2_idx) && (in_rs2_idx != '0)) rs2_eff = wb_data;
    end
`else
    assign rs1_eff = in_rs1_val;
    assign rs2_eff = in_rs2_val;
`endif

    issue_entry_t dec_entry;

    alu_op_decode u_decode (
        .opcode  (in_opcode),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .pc      (in_pc),
        .rs1_val (rs1_eff),
        .rs2_val (rs2_eff),
        .imm     (in_imm),
        .rd      (in_rd),
        .entry   (dec_entry)
    );

    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_valid_q;
    logic         skid_valid_q;
    logic         accept;
    logic         main_load;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign main_load = !main_valid_q || out_ready;

    // Skid buffer: main feeds the ALU, skid absorbs one input while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_load) begin
            if (skid_valid_q) begin
                // in_ready was low, so no input can arrive in the same cycle
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q       <= dec_entry;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_x       = main_q.x;
    assign out_y       = main_q.y;
    assign out_select  = main_q.select;
    assign out_rs2_val = main_q.rs2_val;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic against a
// FIFO-of-two reference model with an instruction-level decode table.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [3:0]  out_select;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_pc       (in_pc),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_imm      (in_imm),
        .in_rd       (in_rd),
`ifdef ALU_ISSUE_FWD_EN
        .in_rs1_idx  (in_rs1_idx),
        .in_rs2_idx  (in_rs2_idx),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_select  (out_select),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  i1;
        logic [4:0]  i2;
    } instr_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  sel;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    instr_t nop_i = '{default: '0};
    instr_t i1, i2, i3, r;
    logic [6:0] opc_tab [0:8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67, 7'h6f, 7'h63};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] pc, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [4:0] rd);
        instr_t t;
        t = '{op: op, f3: f3, f7: f7, pc: pc, rs1: rs1, rs2: rs2, imm: imm, rd: rd,
              i1: 5'd0, i2: 5'd0};
        return t;
    endfunction

    // Instruction-level meaning of each RV32I form in terms of ALU operands
    function automatic exp_t ref_decode(input instr_t i);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        a = i.rs1;
        b = i.rs2;
`ifdef ALU_ISSUE_FWD_EN
        if (wb_valid && i.i1 != 5'd0 && wb_rd == i.i1) a = wb_data;
        if (wb_valid && i.i2 != 5'd0 && wb_rd == i.i2) b = wb_data;
`endif
        e = '{x: 32'd0, y: 32'd0, sel: 4'd0, st: b, rd: i.rd, ill: 1'b0};
        case (i.op)
            7'h33: begin
                e.x   = a;
                e.y   = b;
                e.sel = {i.f7[5], i.f3};
                e.ill = !((i.f7 == 7'h00) || (i.f7 == 7'h20 && (i.f3 == 3'd0 || i.f3 == 3'd5)));
            end
            7'h13: begin
                e.x   = a;
                e.y   = i.imm;
                e.sel = {(i.f3 == 3'd5) ? i.f7[5] : 1'b0, i.f3};
            end
            7'h37: begin
                e.y   = i.imm;
                e.sel = 4'hf;
            end
            7'h17, 7'h6f: begin
                e.x = i.pc;
                e.y = i.imm;
            end
            7'h03, 7'h23, 7'h67: begin
                e.x = a;
                e.y = i.imm;
            end
            7'h63: begin
                e.x = a;
                e.y = b;
                if (i.f3 == 3'd2 || i.f3 == 3'd3) e.ill = 1'b1;
                else if (i.f3 < 3'd4) e.sel = 4'h8;
                else if (i.f3 < 3'd6) e.sel = 4'h2;
                else e.sel = 4'h3;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.x   = 32'd0;
            e.y   = 32'd0;
            e.sel = 4'd0;
        end
        return e;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model
    task automatic cycle(input instr_t ins, input logic v, input logic ordy);
        exp_t e;
        logic exp_rdy;
        exp_rdy = (q.size() < 2);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_x", out_x, q[0].x);
            chk("out_y", out_y, q[0].y);
            chk("out_select", out_select, q[0].sel);
            chk("out_rs2_val", out_rs2_val, q[0].st);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_illegal", out_illegal, q[0].ill);
        end
        in_valid   = v;
        out_ready  = ordy;
        in_opcode  = ins.op;
        in_funct3  = ins.f3;
        in_funct7  = ins.f7;
        in_pc      = ins.pc;
        in_rs1_val = ins.rs1;
        in_rs2_val = ins.rs2;
        in_imm     = ins.imm;
        in_rd      = ins.rd;
`ifdef ALU_ISSUE_FWD_EN
        in_rs1_idx = ins.i1;
        in_rs2_idx = ins.i2;
`endif
        e = ref_decode(ins);
        @(posedge clk);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (v && exp_rdy) q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_pc = '0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0;
`ifdef ALU_ISSUE_FWD_EN
        in_rs1_idx = '0; in_rs2_idx = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_select", out_select, 4'd0);
        chk("rst_rs2_val", out_rs2_val, 32'd0);
        chk("rst_rd", out_rd, 5'd0);
        chk("rst_illegal", out_illegal, 1'b0);

        // ADD x3 <- 5 + 7
        cycle(mk(7'h33, 3'd0, 7'h00, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3), 1'b1, 1'b1);
        chk("add_valid", out_valid, 1'b1);
        chk("add_x", out_x, 32'd5);
        chk("add_y", out_y, 32'd7);
        chk("add_sel", out_select, 4'b0000);
        chk("add_rd", out_rd, 5'd3);

        cycle(mk(7'h33, 3'd0, 7'h20, 32'h0, 32'd9, 32'd4, 32'd0, 5'd1), 1'b1, 1'b1);
        chk("sub_sel", out_select, 4'b1000);
        cycle(mk(7'h13, 3'd5, 7'h20, 32'h0, 32'd9, 32'd0, 32'd4, 5'd2), 1'b1, 1'b1);
        chk("srai_sel", out_select, 4'b1101);
        chk("srai_y", out_y, 32'd4);
        cycle(mk(7'h13, 3'd5, 7'h00, 32'h0, 32'd9, 32'd0, 32'd4, 5'd2), 1'b1, 1'b1);
        chk("srli_sel", out_select, 4'b0101);
        cycle(mk(7'h37, 3'd0, 7'h00, 32'h0, 32'd1, 32'd2, 32'h12345000, 5'd4), 1'b1, 1'b1);
        chk("lui_sel", out_select, 4'b1111);
        chk("lui_y", out_y, 32'h12345000);
        cycle(mk(7'h17, 3'd0, 7'h00, 32'h100, 32'd1, 32'd2, 32'h1000, 5'd5), 1'b1, 1'b1);
        chk("auipc_x", out_x, 32'h100);
        chk("auipc_sel", out_select, 4'b0000);
        cycle(mk(7'h33, 3'd0, 7'h01, 32'h0, 32'd3, 32'd4, 32'd0, 5'd6), 1'b1, 1'b1);
        chk("illegal_flag", out_illegal, 1'b1);
        chk("illegal_sel", out_select, 4'b0000);
        chk("illegal_x", out_x, 32'd0);
        cycle(nop_i, 1'b0, 1'b1);

        // Backpressure: three offered while stalled, two held, strict order on release
        i1 = mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h11, 32'h1, 32'd0, 5'd7);
        i2 = mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h22, 32'h2, 32'd0, 5'd8);
        i3 = mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h33, 32'h3, 32'd0, 5'd9);
        cycle(i1, 1'b1, 1'b0);
        cycle(i2, 1'b1, 1'b0);
        chk("stall_in_ready", in_ready, 1'b0);
        cycle(i3, 1'b1, 1'b0);
        chk("stall_hold_x", out_x, 32'h11);
        cycle(i3, 1'b1, 1'b1);
        chk("release_2nd_x", out_x, 32'h22);
        cycle(i3, 1'b1, 1'b1);
        chk("release_3rd_x", out_x, 32'h33);
        cycle(nop_i, 1'b0, 1'b1);
        cycle(nop_i, 1'b0, 1'b1);

        // Reset with both entries full drops everything immediately
        cycle(i1, 1'b1, 1'b0);
        cycle(i2, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_x", out_x, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hAA;
        r = mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h55, 32'h66, 32'd0, 5'd1);
        r.i1 = 5'd5;
        cycle(r, 1'b1, 1'b1);
        chk("fwd_x", out_x, 32'hAA);
        wb_rd = 5'd0;
        r.i1  = 5'd0;
        cycle(r, 1'b1, 1'b1);
        chk("fwd_x0_x", out_x, 32'h55);
        wb_valid = 1'b0;
`endif

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            int sel_op;
            sel_op = $urandom_range(0, 9);
            r.op  = (sel_op == 9) ? 7'($urandom) : opc_tab[sel_op];
            r.f3  = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    r.f7 = 7'h00;
                2:       r.f7 = 7'h20;
                default: r.f7 = 7'($urandom);
            endcase
            r.pc  = $urandom;
            r.rs1 = $urandom;
            r.rs2 = $urandom;
            r.imm = $urandom;
            r.rd  = 5'($urandom);
            r.i1  = 5'($urandom_range(0, 3));
            r.i2  = 5'($urandom_range(0, 3));
`ifdef ALU_ISSUE_FWD_EN
            wb_valid = 1'($urandom);
            wb_rd    = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
`endif
            cycle(r, 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 3; k++) cycle(nop_i, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
